// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two memory requesters, the memory macro and mem_port_arbiter.
//  slave  : the arbiter's view (requests and memory read data in; grants, dones, read data
//           and the registered memory bus out).
//  master : the environment's view (CPU controller, program loader and memory macro).
// Signals
//  cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request, direction, address, write data
//  cpu_gnt/cpu_done/cpu_rdata         CPU ownership, completion pulse, read data
//  ld_req/ld_we/ld_addr/ld_wdata      loader request, direction, address, write data
//  ld_lock                            loader asks to keep ownership for its next access
//  ld_gnt/ld_done/ld_rdata            loader ownership, completion pulse, read data
//  mem_addr/mem_we/mem_wdata          registered memory address, write strobe, write data
//  mem_rdata                          memory read data
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_lock;
  logic              ld_gnt;
  logic              ld_done;
  logic [DATA_W-1:0] ld_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
    output ld_gnt, ld_done, ld_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
    input  ld_gnt, ld_done, ld_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-port program/data memory between the CPU controller and the external
// program loader. Round-robin arbitration with an optional bounded loader lock, one access
// in flight, registered memory address/write data.
// Ports
//  clk      system clock, all state on the rising edge
//  RESET_n  asynchronous active-low reset
//  bus      mem_port_arbiter_if.slave: both requester ports plus the memory macro bus
// Access sequence: IDLE -> ACC (1) -> WAIT (MEM_LAT-1, absent for MEM_LAT=1) -> DONE (1).
// Read data is captured at the end of DONE; done pulses in the cycle after DONE.
// MEM_LAT legal range 1..3, LOCK_MAX legal range >= 1.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned LOCK_MAX = 8
) (
  input logic               clk,
  input logic               RESET_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned    LockW    = $clog2(LOCK_MAX + 1);
  localparam logic [LockW-1:0] LockMax = LockW'(LOCK_MAX);
  // WAIT runs MEM_LAT-1 cycles: the counter is loaded with MEM_LAT-2 and exits at zero.
  localparam logic [1:0]     WaitInit = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {StIdle, StAcc, StWait, StDone} state_e;
  typedef enum logic {OwnCpu, OwnLd} owner_e;

  state_e            state_q, state_d;
  logic [1:0]        wait_q, wait_d;
  owner_e            owner_q, last_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q, ld_rdata_q;
  logic              cpu_done_q, ld_done_q;
  logic [LockW-1:0]  lock_q;
  logic              grant_cpu, grant_ld, ld_priority;

  // State register
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= StIdle;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Arbitration, only meaningful in IDLE
  always_comb begin
    grant_cpu   = 1'b0;
    grant_ld    = 1'b0;
    ld_priority = bus.ld_req && bus.ld_lock && (lock_q < LockMax);
    if (state_q == StIdle) begin
      if (ld_priority) begin
        grant_ld = 1'b1;
      end else if (bus.cpu_req && bus.ld_req) begin
        // Tie goes to whoever did not own the previous access
        if (last_q == OwnLd) begin
          grant_cpu = 1'b1;
        end else begin
          grant_ld = 1'b1;
        end
      end else begin
        grant_cpu = bus.cpu_req;
        grant_ld  = bus.ld_req;
      end
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      StIdle: begin
        if (grant_cpu || grant_ld) begin
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (MEM_LAT > 1) begin
          state_d = StWait;
          wait_d  = WaitInit;
        end else begin
          state_d = StDone;
        end
      end
      StWait: begin
        if (wait_q == 2'd0) begin
          state_d = StDone;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request latch, lock counter, read data capture and done pulses
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      owner_q     <= OwnCpu;
      last_q      <= OwnLd;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
      cpu_done_q  <= 1'b0;
      ld_done_q   <= 1'b0;
      lock_q      <= '0;
    end else begin
      cpu_done_q <= 1'b0;
      ld_done_q  <= 1'b0;

      if (state_q == StIdle) begin
        if (grant_cpu || !bus.ld_lock) begin
          lock_q <= '0;
        end else if (grant_ld && (lock_q < LockMax)) begin
          lock_q <= lock_q + LockW'(1);
        end

        if (grant_cpu) begin
          owner_q <= OwnCpu;
          we_q    <= bus.cpu_we;
          addr_q  <= bus.cpu_addr;
          wdata_q <= bus.cpu_wdata;
        end else if (grant_ld) begin
          owner_q <= OwnLd;
          we_q    <= bus.ld_we;
          addr_q  <= bus.ld_addr;
          wdata_q <= bus.ld_wdata;
        end
      end

      if (state_q == StDone) begin
        last_q <= owner_q;
        if (owner_q == OwnCpu) begin
          cpu_done_q <= 1'b1;
          if (!we_q) begin
            cpu_rdata_q <= bus.mem_rdata;
          end
        end else begin
          ld_done_q <= 1'b1;
          if (!we_q) begin
            ld_rdata_q <= bus.mem_rdata;
          end
        end
      end
    end
  end

  // Outputs; mem_we decodes from the async-reset state so it drops as soon as reset asserts
  always_comb begin
    bus.cpu_gnt   = (state_q != StIdle) && (owner_q == OwnCpu);
    bus.ld_gnt    = (state_q != StIdle) && (owner_q == OwnLd);
    bus.cpu_done  = cpu_done_q;
    bus.ld_done   = ld_done_q;
    bus.cpu_rdata = cpu_rdata_q;
    bus.ld_rdata  = ld_rdata_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.mem_we    = (state_q == StAcc) && we_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LOCK_MAX = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter_if #(.ADDR_W(5), .DATA_W(8)) if1 ();
  mem_port_arbiter_if #(.ADDR_W(5), .DATA_W(8)) if3 ();

  mem_port_arbiter #(.ADDR_W(5), .DATA_W(8), .MEM_LAT(1), .LOCK_MAX(LOCK_MAX)) u_dut1 (
    .clk    (clk),
    .RESET_n(rst_n),
    .bus    (if1)
  );

  mem_port_arbiter #(.ADDR_W(5), .DATA_W(8), .MEM_LAT(3), .LOCK_MAX(LOCK_MAX)) u_dut3 (
    .clk    (clk),
    .RESET_n(rst_n),
    .bus    (if3)
  );

  function automatic logic [7:0] init_val(input int i);
    return (i == 3) ? 8'hA5 : 8'((i * 29) ^ 90);
  endfunction

  // Memory macros: synchronous read with MEM_LAT-deep output pipeline
  logic [7:0] mem1 [32];
  logic [7:0] mem3 [32];
  logic [7:0] pipe1;
  logic [7:0] pipe3 [3];
  assign if1.mem_rdata = pipe1;
  assign if3.mem_rdata = pipe3[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem1[i] <= init_val(i);
        mem3[i] <= init_val(i);
      end
      pipe1    <= '0;
      pipe3[0] <= '0;
      pipe3[1] <= '0;
      pipe3[2] <= '0;
    end else begin
      if (if1.mem_we) mem1[if1.mem_addr] <= if1.mem_wdata;
      if (if3.mem_we) mem3[if3.mem_addr] <= if3.mem_wdata;
      pipe1    <= mem1[if1.mem_addr];
      pipe3[0] <= mem3[if3.mem_addr];
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
    end
  end

  function automatic logic [33:0] outs1();
    return {if1.cpu_gnt, if1.cpu_done, if1.cpu_rdata, if1.ld_gnt, if1.ld_done, if1.ld_rdata,
            if1.mem_addr, if1.mem_we, if1.mem_wdata};
  endfunction

  function automatic logic [33:0] outs3();
    return {if3.cpu_gnt, if3.cpu_done, if3.cpu_rdata, if3.ld_gnt, if3.ld_done, if3.ld_rdata,
            if3.mem_addr, if3.mem_we, if3.mem_wdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    if1.cpu_req = 0; if1.cpu_we = 0; if1.cpu_addr = '0; if1.cpu_wdata = '0;
    if1.ld_req  = 0; if1.ld_we  = 0; if1.ld_addr  = '0; if1.ld_wdata  = '0; if1.ld_lock = 0;
    if3.cpu_req = 0; if3.cpu_we = 0; if3.cpu_addr = '0; if3.cpu_wdata = '0;
    if3.ld_req  = 0; if3.ld_we  = 0; if3.ld_addr  = '0; if3.ld_wdata  = '0; if3.ld_lock = 0;
  endtask

  task automatic rst_pulse();
    rst_n = 0;
    set_idle();
    tick();
    rst_n = 1;
    tick();
  endtask

  // One access on the MEM_LAT=1 instance; req dropped as soon as done is seen
  task automatic access1(input bit is_ld, input bit we, input logic [4:0] addr,
                         input logic [7:0] wdata, output int gnt_cyc, output int done_cyc,
                         output int done_cnt, output int we_cnt, output logic [4:0] w_addr,
                         output logic [7:0] w_data, output int regnt);
    gnt_cyc = -1; done_cyc = -1; done_cnt = 0; we_cnt = 0; w_addr = '0; w_data = '0; regnt = 0;
    if (is_ld) begin
      if1.ld_req = 1; if1.ld_we = we; if1.ld_addr = addr; if1.ld_wdata = wdata;
    end else begin
      if1.cpu_req = 1; if1.cpu_we = we; if1.cpu_addr = addr; if1.cpu_wdata = wdata;
    end
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (is_ld ? if1.ld_gnt : if1.cpu_gnt) begin
        if (gnt_cyc < 0) gnt_cyc = c;
        if (done_cyc >= 0) regnt++;
      end
      if (if1.mem_we) begin
        we_cnt++;
        w_addr = if1.mem_addr;
        w_data = if1.mem_wdata;
      end
      if (is_ld ? if1.ld_done : if1.cpu_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
        if (is_ld) if1.ld_req = 0; else if1.cpu_req = 0;
      end
    end
  endtask

  int gseq[$];

  task automatic collect_grants(input int cycles);
    logic pc, pl;
    int both;
    gseq.delete();
    pc = if1.cpu_gnt;
    pl = if1.ld_gnt;
    both = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (if1.cpu_gnt && if1.ld_gnt) both++;
      if (if1.cpu_gnt && !pc) gseq.push_back(1);
      if (if1.ld_gnt && !pl) gseq.push_back(2);
      pc = if1.cpu_gnt;
      pl = if1.ld_gnt;
    end
    n_tests++;
    if (both != 0) begin
      n_fail++;
      $display("FAIL both_gnt: got %0d cycles with both grants, expected 0", both);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_idle();
    repeat (2) tick();
    n_tests++;
    if (outs1() !== 34'd0) begin
      n_fail++; $display("FAIL reset_outs_lat1: got %h expected 0", outs1());
    end
    n_tests++;
    if (outs3() !== 34'd0) begin
      n_fail++; $display("FAIL reset_outs_lat3: got %h expected 0", outs3());
    end
    rst_n = 1;
    repeat (3) tick();
    n_tests++;
    if ({if1.cpu_gnt, if1.ld_gnt, if3.cpu_gnt, if3.ld_gnt} !== 4'b0) begin
      n_fail++; $display("FAIL idle_no_gnt: got %b expected 0000",
                         {if1.cpu_gnt, if1.ld_gnt, if3.cpu_gnt, if3.ld_gnt});
    end
  endtask

  task automatic test_cpu_read();
    int g, d, dc, wc, rg;
    logic [4:0] wa;
    logic [7:0] wd;
    access1(1'b0, 1'b0, 5'h03, 8'h00, g, d, dc, wc, wa, wd, rg);
    n_tests++;
    if (g != 1) begin n_fail++; $display("FAIL cpu_read_gnt_cyc: got %0d expected 1", g); end
    n_tests++;
    if (d != 3) begin n_fail++; $display("FAIL cpu_read_done_cyc: got %0d expected 3", d); end
    n_tests++;
    if (dc != 1 || wc != 0 || rg != 0) begin
      n_fail++; $display("FAIL cpu_read_counts: got done=%0d we=%0d regnt=%0d expected 1 0 0",
                         dc, wc, rg);
    end
    n_tests++;
    if (if1.cpu_rdata !== 8'hA5) begin
      n_fail++; $display("FAIL cpu_read_data: got %h expected a5", if1.cpu_rdata);
    end
  endtask

  task automatic test_ld_write();
    int g, d, dc, wc, rg;
    logic [4:0] wa;
    logic [7:0] wd;
    access1(1'b1, 1'b0, 5'h01, 8'h00, g, d, dc, wc, wa, wd, rg);
    n_tests++;
    if (if1.ld_rdata !== init_val(1) || d != 3) begin
      n_fail++; $display("FAIL ld_read: got data %h done_cyc %0d expected %h 3",
                         if1.ld_rdata, d, init_val(1));
    end
    access1(1'b1, 1'b1, 5'h1F, 8'h3C, g, d, dc, wc, wa, wd, rg);
    n_tests++;
    if (wc != 1 || wa !== 5'h1F || wd !== 8'h3C) begin
      n_fail++; $display("FAIL ld_write_bus: got we_cycles=%0d addr=%h data=%h expected 1 1f 3c",
                         wc, wa, wd);
    end
    n_tests++;
    if (dc != 1 || if1.ld_rdata !== init_val(1)) begin
      n_fail++; $display("FAIL ld_write_done: got done=%0d rdata=%h expected 1 %h",
                         dc, if1.ld_rdata, init_val(1));
    end
    access1(1'b0, 1'b0, 5'h1F, 8'h00, g, d, dc, wc, wa, wd, rg);
    n_tests++;
    if (if1.cpu_rdata !== 8'h3C) begin
      n_fail++; $display("FAIL ld_write_readback: got %h expected 3c", if1.cpu_rdata);
    end
  endtask

  task automatic test_drop();
    int d, dc, rg;
    d = -1; dc = 0; rg = 0;
    if1.cpu_req = 1; if1.cpu_we = 0; if1.cpu_addr = 5'h05;
    tick();
    n_tests++;
    if (if1.cpu_gnt !== 1'b1) begin
      n_fail++; $display("FAIL drop_gnt: got %b expected 1", if1.cpu_gnt);
    end
    if1.cpu_req = 0;
    for (int c = 2; c <= 10; c++) begin
      tick();
      if (if1.cpu_gnt && d >= 0) rg++;
      if (if1.cpu_done) begin
        dc++;
        if (d < 0) d = c;
      end
    end
    n_tests++;
    if (dc != 1 || d != 3 || rg != 0) begin
      n_fail++; $display("FAIL drop_done: got done=%0d at %0d regnt=%0d expected 1 at 3, 0",
                         dc, d, rg);
    end
    n_tests++;
    if (if1.cpu_rdata !== init_val(5)) begin
      n_fail++; $display("FAIL drop_data: got %h expected %h", if1.cpu_rdata, init_val(5));
    end
  endtask

  task automatic test_alternate();
    rst_pulse();
    if1.cpu_req = 1; if1.cpu_we = 0; if1.cpu_addr = 5'h02;
    if1.ld_req  = 1; if1.ld_we  = 0; if1.ld_addr  = 5'h04; if1.ld_lock = 0;
    collect_grants(20);
    set_idle();
    repeat (4) tick();
    n_tests++;
    if (gseq.size() < 6) begin
      n_fail++; $display("FAIL alt_count: got %0d grants expected >= 6", gseq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_tests++;
        if (gseq[i] != ((i % 2 == 0) ? 1 : 2)) begin
          n_fail++; $display("FAIL alt_order[%0d]: got owner %0d expected %0d", i, gseq[i],
                             (i % 2 == 0) ? 1 : 2);
        end
      end
    end
  endtask

  task automatic test_lock();
    if1.cpu_req = 1; if1.cpu_we = 0; if1.cpu_addr = 5'h06;
    if1.ld_req  = 1; if1.ld_we  = 0; if1.ld_addr  = 5'h08; if1.ld_lock = 1;
    collect_grants(45);
    set_idle();
    repeat (4) tick();
    n_tests++;
    if (gseq.size() < 11) begin
      n_fail++; $display("FAIL lock_count: got %0d grants expected >= 11", gseq.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        n_tests++;
        if (gseq[i] != ((i == LOCK_MAX) ? 1 : 2)) begin
          n_fail++; $display("FAIL lock_order[%0d]: got owner %0d expected %0d", i, gseq[i],
                             (i == LOCK_MAX) ? 1 : 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int g, d, dc;
    if3.cpu_req = 1; if3.cpu_we = 1; if3.cpu_addr = 5'h07; if3.cpu_wdata = 8'h11;
    tick();
    n_tests++;
    if ({if3.cpu_gnt, if3.mem_we} !== 2'b11) begin
      n_fail++; $display("FAIL mid_acc: got gnt/we %b expected 11", {if3.cpu_gnt, if3.mem_we});
    end
    tick();
    n_tests++;
    if ({if3.cpu_gnt, if3.mem_we} !== 2'b10) begin
      n_fail++; $display("FAIL mid_wait: got gnt/we %b expected 10", {if3.cpu_gnt, if3.mem_we});
    end
    rst_n = 0;
    #1;
    n_tests++;
    if (outs3() !== 34'd0) begin
      n_fail++; $display("FAIL mid_reset_lat3: got %h expected 0", outs3());
    end
    n_tests++;
    if (outs1() !== 34'd0) begin
      n_fail++; $display("FAIL mid_reset_lat1: got %h expected 0", outs1());
    end
    set_idle();
    repeat (2) tick();
    rst_n = 1;
    tick();
    n_tests++;
    if ({if3.cpu_gnt, if3.ld_gnt, if3.cpu_done, if3.ld_done} !== 4'b0) begin
      n_fail++; $display("FAIL mid_idle: got %b expected 0000",
                         {if3.cpu_gnt, if3.ld_gnt, if3.cpu_done, if3.ld_done});
    end
    g = -1; d = -1; dc = 0;
    if3.cpu_req = 1; if3.cpu_we = 0; if3.cpu_addr = 5'h09;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (if3.cpu_gnt && g < 0) g = c;
      if (if3.cpu_done) begin
        dc++;
        if (d < 0) d = c;
        if3.cpu_req = 0;
      end
    end
    n_tests++;
    if (g != 1 || d != 5 || dc != 1) begin
      n_fail++; $display("FAIL mid_after: got gnt %0d done %0d x%0d expected 1 5 x1", g, d, dc);
    end
    n_tests++;
    if (if3.cpu_rdata !== init_val(9)) begin
      n_fail++; $display("FAIL mid_after_data: got %h expected %h", if3.cpu_rdata, init_val(9));
    end
  endtask

  // Cycle model: an access holds the port for 1+MEM_LAT cycles, done follows; accesses apply
  // to a reference memory in completion order.
  task automatic test_random();
    logic [7:0] ref_mem [32];
    int m_own, m_rem, m_last, m_lock, win, lock_bias;
    logic m_we;
    logic [4:0] m_addr;
    logic [7:0] m_wdata, m_crd, m_lrd;
    bit e_cd, e_ld, e_acc;
    rst_pulse();
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    m_own = 0; m_rem = 0; m_last = 2; m_lock = 0; lock_bias = 9;
    m_we = 0; m_addr = '0; m_wdata = '0; m_crd = '0; m_lrd = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      e_cd = 0; e_ld = 0; e_acc = 0;
      if (m_own != 0) begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_we) ref_mem[m_addr] = m_wdata;
          else if (m_own == 1) m_crd = ref_mem[m_addr];
          else m_lrd = ref_mem[m_addr];
          if (m_own == 1) e_cd = 1; else e_ld = 1;
          m_last = m_own;
          m_own = 0;
        end
      end else begin
        if (if1.ld_req && if1.ld_lock && m_lock < LOCK_MAX) win = 2;
        else if (if1.cpu_req && if1.ld_req) win = (m_last == 2) ? 1 : 2;
        else if (if1.cpu_req) win = 1;
        else if (if1.ld_req) win = 2;
        else win = 0;
        if (win == 1 || !if1.ld_lock) m_lock = 0;
        else if (win == 2 && m_lock < LOCK_MAX) m_lock++;
        if (win == 1) begin
          m_we = if1.cpu_we; m_addr = if1.cpu_addr; m_wdata = if1.cpu_wdata;
        end else if (win == 2) begin
          m_we = if1.ld_we; m_addr = if1.ld_addr; m_wdata = if1.ld_wdata;
        end
        if (win != 0) begin
          m_own = win; m_rem = 2; e_acc = 1;
        end
      end

      n_tests++;
      if ({if1.cpu_gnt, if1.ld_gnt, if1.cpu_done, if1.ld_done, if1.mem_we} !==
          {m_own == 1, m_own == 2, e_cd, e_ld, e_acc && m_we}) begin
        n_fail++;
        $display("FAIL rand_ctrl @%0d: got gnt/done/we %b expected %b", cyc,
                 {if1.cpu_gnt, if1.ld_gnt, if1.cpu_done, if1.ld_done, if1.mem_we},
                 {m_own == 1, m_own == 2, e_cd, e_ld, e_acc && m_we});
      end
      n_tests++;
      if ({if1.cpu_rdata, if1.ld_rdata} !== {m_crd, m_lrd}) begin
        n_fail++; $display("FAIL rand_rdata @%0d: got %h %h expected %h %h", cyc,
                           if1.cpu_rdata, if1.ld_rdata, m_crd, m_lrd);
      end
      if (e_acc && m_we) begin
        n_tests++;
        if ({if1.mem_addr, if1.mem_wdata} !== {m_addr, m_wdata}) begin
          n_fail++; $display("FAIL rand_wbus @%0d: got %h/%h expected %h/%h", cyc,
                             if1.mem_addr, if1.mem_wdata, m_addr, m_wdata);
        end
      end

      if (e_cd) if1.cpu_req = 0;
      if (e_ld) if1.ld_req = 0;
      if (!if1.cpu_req && $urandom_range(0, 2) == 0) begin
        if1.cpu_req = 1; if1.cpu_we = 1'($urandom_range(0, 1));
        if1.cpu_addr = 5'($urandom); if1.cpu_wdata = 8'($urandom);
      end
      if (!if1.ld_req && $urandom_range(0, 1) == 0) begin
        if1.ld_req = 1; if1.ld_we = 1'($urandom_range(0, 1));
        if1.ld_addr = 5'($urandom); if1.ld_wdata = 8'($urandom);
      end
      if (cyc % 150 == 149) lock_bias = (lock_bias == 9) ? 2 : 9;
      if1.ld_lock = ($urandom_range(0, 9) < lock_bias);
    end
    set_idle();
    repeat (5) tick();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_cpu_read();
    test_ld_write();
    test_drop();
    test_alternate();
    test_lock();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
